adder_checker: RTL

Synthesizable response checker for the W-bit registered adder, sitting at the output side of the adder datapath opposite the stimulus source. For every accepted stimulus pair it computes the expected W+1-bit sum and delays it to match the adder latency. It compares that value with the adder's `out` and tallies checked vectors and mismatches. It reports pass/fail on-chip, so a run completes without simulator-only constructs.

---
 rtl/adder_chk_pkg.sv | 6 +
 rtl/adder_checker_pipe.sv | 30 +++
 rtl/adder_checker.sv | 100 ++++++++++
 3 files changed

// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared state encoding, count type and latency bound for adder_checker.
package adder_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [15:0] cnt_t;
  localparam int LAT_MAX = 8;
endpackage

// File: rtl/adder_checker_pipe.sv
// expect_pipe: LAT-deep shift register of {valid, expected sum}, async active-low clear.
module expect_pipe #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W:0]   i_val,
  output logic         o_valid,
  output logic [W:0]   o_val
);
  logic [LAT-1:0] r_v;
  logic [W:0]     r_d [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < LAT; i++) r_d[i] <= '0;
    end else begin
      r_v[0] <= i_valid;
      r_d[0] <= i_val;
      for (int i = 1; i < LAT; i++) begin
        r_v[i] <= r_v[i-1];
        r_d[i] <= r_d[i-1];
      end
    end
  end
  assign o_valid = r_v[LAT-1];
  assign o_val   = r_d[LAT-1];
endmodule

// File: rtl/adder_checker.sv
// adder_checker: on-chip response checker for a W-bit registered adder.
// Define ADDER_CHECKER_FIRST_ERR_EN to build the first-mismatch capture registers.
module adder_checker
  import adder_chk_pkg::*;
#(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [15:0]  test_len,
  input  logic         in_valid,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic [W:0]   sum,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  chk_count,
  output logic [15:0]  err_count,
  output logic [W:0]   first_exp,
  output logic [W:0]   first_act
);
  if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
    $error("adder_checker: LAT out of range");
  end
  state_t     r_state, w_next;
  cnt_t       r_len, r_iss, r_chk, r_err;
  logic       r_pass;
  logic       w_start, w_push, w_pv, w_cmp, w_mis;
  logic [W:0] w_pval;
  // start is only honoured outside RUN
  assign w_start = start && r_state != RUN;
  assign w_push  = r_state == RUN && in_valid && r_iss < r_len;
  assign w_cmp   = r_state == RUN && w_pv;
  assign w_mis   = w_cmp && w_pval != sum;
  expect_pipe #(.W(W), .LAT(LAT)) u_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_push),
    .i_val   ({1'b0, inA} + {1'b0, inB}),
    .o_valid (w_pv),
    .o_val   (w_pval)
  );
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = test_len == 16'd0 ? DONE : RUN;
    else if (r_state == RUN && r_chk == r_len) w_next = DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_iss  <= '0;
      r_chk  <= '0;
      r_err  <= '0;
      r_pass <= 1'b0;
    end else if (w_start) begin
      r_len  <= test_len;
      r_iss  <= '0;
      r_chk  <= '0;
      r_err  <= '0;
      r_pass <= test_len == 16'd0;
    end else begin
      if (w_push) r_iss <= r_iss + 16'd1;
      if (w_cmp) r_chk <= r_chk + 16'd1;
      if (w_mis && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
      if (r_state == RUN && w_next == DONE) r_pass <= r_err == 16'd0;
    end
  end
`ifdef ADDER_CHECKER_FIRST_ERR_EN
  logic [W:0] r_fexp, r_fact;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || 1'b0) begin
      r_fexp <= '0;
      r_fact <= '0;
    end else if (w_start) begin
      r_fexp <= '0;
      r_fact <= '0;
    end else if (w_mis && r_err == 16'd0) begin
      r_fexp <= w_pval;
      r_fact <= sum;
    end
  end
  assign first_exp = r_fexp;
  assign first_act = r_fact;
`else
  assign first_exp = '0;
  assign first_act = '0;
`endif
  assign busy      = r_state == RUN;
  assign done      = r_state == DONE;
  assign pass      = r_pass;
  assign chk_count = r_chk;
  assign err_count = r_err;
endmodule
